npu_sdram_dma: RTL
==================

Name: npu_sdram_dma

Overview:
- FPGA-side initiator for the SDRAM wrapper's read/write/rw conduits; moves bursts of 128-bit beats between HPS SDRAM and an on-chip NPU tile buffer.
- Accepts one command at a time from the NPU sequencer.
- Read: SDRAM -> buffer. Write: buffer -> SDRAM.
- Drives rw_addr/rw_cnt, pulses read_start or write_start, consumes read_valid/read_data, feeds write_data on write_nxt, finishes on rw_done.

Parameters:
- BUF_AW, 10, tile-buffer address width in beats.
- DW, 128, beat width; must equal the wrapper data width.

Ports:
- clk  in  1  system clock; same clock as the wrapper conduits.
- reset  in  1  synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = buffer->SDRAM, 0 = SDRAM->buffer.
- cmd_sdram_addr  in  32  byte address; bits[3:0] must be 0.
- cmd_buf_addr  in  BUF_AW  first buffer beat index.
- cmd_len  in  11  beat count, legal range 1..1024.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle pulse at command end.
- err  out  1  sticky error; cleared when the next command is accepted.
- rw_addr  out  32  to wrapper.
- rw_cnt  out  11  to wrapper.
- rw_done  in  1  from wrapper; one-cycle pulse.
- read_start  out  1  one-cycle pulse.
- read_data  in  DW  read beat.
- read_valid  in  1  read beat qualifier.
- write_start  out  1  one-cycle pulse.
- write_data  out  DW  current write beat.
- write_nxt  in  1  wrapper consumed the current beat.
- buf_wr_en  out  1  tile-buffer write enable.
- buf_wr_addr  out  BUF_AW  tile-buffer write address.
- buf_wr_data  out  DW  tile-buffer write data.
- buf_rd_en  out  1  tile-buffer read enable.
- buf_rd_addr  out  BUF_AW  tile-buffer read address.
- buf_rd_data  in  DW  tile-buffer read data; 1-cycle latency after buf_rd_en.

Behaviour:
- Reset: all outputs 0 except cmd_ready=1. State = IDLE, prefetch FIFO empty, err=0. Reset mid-transfer aborts immediately. The wrapper shares this reset, so no conduit cleanup is done.
- States: IDLE, CHECK, RD_START, RD_DATA, WR_PRIME, WR_START, WR_DATA, DONE.
- IDLE: on cmd_valid & cmd_ready, latch all cmd fields, clear err, go to CHECK.
- CHECK (1 cycle):
  - cmd_len==0, cmd_len>1024, or sdram_addr[3:0]!=0 -> set err, go to DONE. No wrapper activity.
  - Otherwise go to RD_START or WR_PRIME per cmd_write.
- rw_addr/rw_cnt are registered from the latched command. They hold stable from CHECK exit until the cycle after rw_done, and are 0 in IDLE.
- RD_START: read_start=1 for exactly one cycle, then RD_DATA.
- RD_DATA:
  - Each read_valid cycle writes beat i to the buffer.
  - buf_wr_en/addr/data are registered: asserted the cycle after read_valid, with addr = buf_base + i mod 2^BUF_AW (wraps silently).
  - Beats beyond len are dropped and set err.
  - rw_done -> DONE. If fewer than len beats were received, set err.
  - read_valid and rw_done in the same cycle: the beat counts, then done is evaluated.
- WR_PRIME:
  - 2-entry prefetch FIFO fed from the buffer.
  - Issue buf_rd_en while (occupancy + in-flight) < 2 and issued < len. Addresses increment with wrap.
  - When the FIFO holds the head beat, go to WR_START.
- WR_START: write_start=1 for one cycle, then WR_DATA.
- WR_DATA:
  - write_data = FIFO head (combinational from the FIFO register). It is valid every cycle while beats remain, and 0 when the FIFO is empty.
  - write_nxt pops the head. The refill read is issued in the same cycle as the pop, so back-to-back write_nxt every cycle is sustained without a bubble.
  - Pop and arrival in the same cycle: occupancy unchanged.
  - write_nxt with an empty FIFO, or after len pops: set err, ignore the pulse.
  - rw_done -> DONE. If pops != len, set err.
- DONE: done=1 for one cycle, cmd_ready stays 0; next cycle return to IDLE. err holds.
- Latency: cmd accept to read_start/write_start = 2 cycles for a read, 4 cycles minimum for a write.

Test Plan:
1. Read, addr 0x3000_0000, buf 0x010, len 4; wrapper returns beats A0..A3 on consecutive cycles then rw_done -> read_start pulses 2 cycles after accept; buf writes A0..A3 at 0x010..0x013 each one cycle after read_valid; done pulse; err=0; rw_cnt=4 throughout.
2. Write, len 8, buffer preloaded with B0..B7, write_nxt asserted 8 consecutive cycles -> write_data shows B0..B7 with no repeats or bubbles; rw_done -> done pulse; err=0.
3. Write, len 3, write_nxt gapped (1,0,0,1,0,1) -> B0,B1,B2 each presented until its write_nxt; FIFO never underflows; err=0.
4. Read, buf 0x3FE, len 4 (BUF_AW=10) -> buffer writes at 0x3FE, 0x3FF, 0x000, 0x001.
5. Illegal commands (len 0; addr 0x...0008) -> no read_start/write_start; done pulse 2 cycles after accept; err=1. Next legal command clears err on accept.
6. Reset asserted mid RD_DATA after 2 of 6 beats -> next cycle busy=0, cmd_ready=1, all strobes 0. Early rw_done after 2 of 4 read beats -> done pulse with err=1.

Source files
------------

// File: rtl/npu_sdram_dma.sv
// npu_sdram_dma
//   Moves bursts of DW-bit beats between HPS SDRAM (through the SDRAM
//   wrapper's rw/read/write conduits) and an on-chip NPU tile buffer.
//   One command at a time; read = SDRAM -> buffer, write = buffer -> SDRAM.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   cmd_*                 : command handshake from the NPU sequencer
//   busy, done, err       : status (done is a 1-cycle pulse, err is sticky)
//   rw_addr, rw_cnt       : burst address / beat count to the wrapper
//   rw_done               : burst-complete pulse from the wrapper
//   read_start/data/valid : read conduit
//   write_start/data/nxt  : write conduit (write_data is the prefetch head)
//   buf_wr_*              : tile-buffer write port (registered)
//   buf_rd_*              : tile-buffer read port (1-cycle read latency)
module npu_sdram_dma #(
    parameter int BUF_AW = 10,
    parameter int DW     = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_sdram_addr,
    input  logic [BUF_AW-1:0] cmd_buf_addr,
    input  logic [10:0]       cmd_len,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rw_addr,
    output logic [10:0]       rw_cnt,
    input  logic              rw_done,
    output logic              read_start,
    input  logic [DW-1:0]     read_data,
    input  logic              read_valid,
    output logic              write_start,
    output logic [DW-1:0]     write_data,
    input  logic              write_nxt,
    output logic              buf_wr_en,
    output logic [BUF_AW-1:0] buf_wr_addr,
    output logic [DW-1:0]     buf_wr_data,
    output logic              buf_rd_en,
    output logic [BUF_AW-1:0] buf_rd_addr,
    input  logic [DW-1:0]     buf_rd_data
);

    typedef enum logic [2:0] {
        IDLE, CHECK, RD_START, RD_DATA, WR_PRIME, WR_START, WR_DATA, DONE
    } state_t;

    state_t            state;
    logic              dir_wr;
    logic [31:0]       sd_addr;
    logic [BUF_AW-1:0] buf_base;
    logic [10:0]       len;
    logic [10:0]       issued;   // buffer reads issued (write direction)
    logic [10:0]       beats;    // beats written to buffer / popped to wrapper

    // 2-entry prefetch FIFO, head always in fifo0
    logic [DW-1:0]     fifo0, fifo1;
    logic [1:0]        occ;
    logic              inflight; // buffer read issued last cycle, data arrives now

    logic              pop, issue, rd_take, wr_phase;
    logic [2:0]        level;

    always_comb begin
        wr_phase = (state == WR_PRIME) || (state == WR_START) || (state == WR_DATA);
        pop      = (state == WR_DATA) && write_nxt && (occ != 2'd0) && (beats < len);
        level    = 3'(occ) + 3'(inflight);
        // Counting the same-cycle pop lets the refill go out with the pop,
        // which is what keeps back-to-back write_nxt bubble-free.
        issue    = wr_phase && (issued < len) && (level < (3'd2 + 3'(pop)));
        rd_take  = (state == RD_DATA) && read_valid && (beats < len);

        buf_rd_en   = issue;
        buf_rd_addr = issue ? (buf_base + BUF_AW'(issued)) : '0;
        write_data  = (occ != 2'd0) ? fifo0 : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dir_wr      <= 1'b0;
            sd_addr     <= '0;
            buf_base    <= '0;
            len         <= '0;
            issued      <= '0;
            beats       <= '0;
            fifo0       <= '0;
            fifo1       <= '0;
            occ         <= '0;
            inflight    <= 1'b0;
            cmd_ready   <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            rw_addr     <= '0;
            rw_cnt      <= '0;
            read_start  <= 1'b0;
            write_start <= 1'b0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
        end else begin
            done        <= 1'b0;
            read_start  <= 1'b0;
            write_start <= 1'b0;
            buf_wr_en   <= 1'b0;
            inflight    <= issue;
            if (issue) issued <= issued + 11'd1;

            // Prefetch FIFO; anything still landing after the command ends is dropped.
            if (state == IDLE || state == DONE) begin
                occ <= 2'd0;
            end else begin
                case ({pop, inflight})
                    2'b01: begin
                        if (occ == 2'd0) fifo0 <= buf_rd_data;
                        else             fifo1 <= buf_rd_data;
                        occ <= occ + 2'd1;
                    end
                    2'b10: begin
                        fifo0 <= fifo1;
                        occ   <= occ - 2'd1;
                    end
                    2'b11: begin
                        if (occ == 2'd1) fifo0 <= buf_rd_data;
                        else begin
                            fifo0 <= fifo1;
                            fifo1 <= buf_rd_data;
                        end
                    end
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        dir_wr    <= cmd_write;
                        sd_addr   <= cmd_sdram_addr;
                        buf_base  <= cmd_buf_addr;
                        len       <= cmd_len;
                        issued    <= '0;
                        beats     <= '0;
                        err       <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    if (len == 11'd0 || len > 11'd1024 || sd_addr[3:0] != 4'd0) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rw_addr <= sd_addr;
                        rw_cnt  <= len;
                        if (dir_wr) state <= WR_PRIME;
                        else begin
                            read_start <= 1'b1;
                            state      <= RD_START;
                        end
                    end
                end
                RD_START: state <= RD_DATA;
                RD_DATA: begin
                    if (rd_take) begin
                        buf_wr_en   <= 1'b1;
                        buf_wr_addr <= buf_base + BUF_AW'(beats);
                        buf_wr_data <= read_data;
                        beats       <= beats + 11'd1;
                    end else if (read_valid) begin
                        err <= 1'b1;            // beat beyond len
                    end
                    if (rw_done) begin
                        if ((beats + 11'(rd_take)) < len) err <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WR_PRIME: begin
                    // head is either already held or arriving this edge
                    if (occ != 2'd0 || inflight) begin
                        write_start <= 1'b1;
                        state       <= WR_START;
                    end
                end
                WR_START: state <= WR_DATA;
                WR_DATA: begin
                    if (pop) beats <= beats + 11'd1;
                    else if (write_nxt) err <= 1'b1;   // underflow or beyond len
                    if (rw_done) begin
                        if ((beats + 11'(pop)) != len) err <= 1'b1;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    rw_addr   <= '0;
                    rw_cnt    <= '0;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
